// File: rtl/imem_arb.sv
// Single-port instruction-memory arbiter between fetch and the program loader.
// Serialises RAM accesses and keeps a one-entry fetch holding register.
`timescale 1ns / 1ps

module imem_arb #(
  parameter int unsigned ADDR_WIDTH = 30,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                  i_clk,
  input  logic                  i_arst_n,
  input  logic                  i_fe_req,
  input  logic [ADDR_WIDTH-1:0] i_fe_addr,
  output logic [DATA_WIDTH-1:0] o_fe_instr,
  output logic                  o_fe_stall,
  input  logic                  i_ld_req,
  input  logic                  i_ld_we,
  input  logic [ADDR_WIDTH-1:0] i_ld_addr,
  input  logic [DATA_WIDTH-1:0] i_ld_wdata,
  output logic                  o_ld_ack,
  output logic [DATA_WIDTH-1:0] o_ld_rdata,
  output logic                  o_mem_en,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

  localparam int unsigned LatW    = $clog2(MEM_LAT + 1);
  localparam int unsigned StarveW = $clog2(STARVE_MAX + 1);
  localparam logic [LatW-1:0]    LatLast   = LatW'(MEM_LAT);
  localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_MAX);

  typedef enum logic [1:0] {StIdle, StFeAcc, StLdAcc} state_e;

  state_e                 state_q, state_d;
  logic [LatW-1:0]        lat_q, lat_d;
  logic [ADDR_WIDTH-1:0]  acc_addr_q, acc_addr_d;
  logic                   acc_we_q, acc_we_d;
  logic [DATA_WIDTH-1:0]  acc_wdata_q, acc_wdata_d;
  logic                   hold_valid_q, hold_valid_d;
  logic [ADDR_WIDTH-1:0]  hold_addr_q, hold_addr_d;
  logic [DATA_WIDTH-1:0]  hold_data_q, hold_data_d;
  logic                   ld_ack_q, ld_ack_d;
  logic [DATA_WIDTH-1:0]  ld_rdata_q, ld_rdata_d;
  logic [StarveW-1:0]     starve_q, starve_d;

  logic hit, fe_inflight, fe_pending, ld_grant, acc_last;

  assign hit         = hold_valid_q && (hold_addr_q == i_fe_addr);
  assign fe_inflight = (state_q == StFeAcc) && (acc_addr_q == i_fe_addr);
  assign fe_pending  = i_fe_req && !hit && !fe_inflight;
  // Loader wins ties until fetch has been passed over STARVE_MAX times.
  assign ld_grant    = i_ld_req && (!fe_pending || (starve_q < StarveMax));
  assign acc_last    = (lat_q == LatLast);

  assign o_fe_stall  = i_fe_req && !hit;
  assign o_fe_instr  = hold_data_q;
  assign o_ld_ack    = ld_ack_q;
  assign o_ld_rdata  = ld_rdata_q;
  assign o_mem_en    = (state_q != StIdle) && !acc_last;
  assign o_mem_we    = acc_we_q;
  assign o_mem_addr  = acc_addr_q;
  assign o_mem_wdata = acc_wdata_q;

  always_comb begin
    state_d      = state_q;
    lat_d        = lat_q;
    acc_addr_d   = acc_addr_q;
    acc_we_d     = acc_we_q;
    acc_wdata_d  = acc_wdata_q;
    hold_valid_d = hold_valid_q;
    hold_addr_d  = hold_addr_q;
    hold_data_d  = hold_data_q;
    ld_ack_d     = 1'b0;
    ld_rdata_d   = ld_rdata_q;
    starve_d     = fe_pending ? starve_q : '0;

    unique case (state_q)
      StIdle: begin
        if (ld_grant) begin
          state_d     = StLdAcc;
          lat_d       = '0;
          acc_addr_d  = i_ld_addr;
          acc_we_d    = i_ld_we;
          acc_wdata_d = i_ld_wdata;
          if (fe_pending) starve_d = starve_q + StarveW'(1);
        end else if (fe_pending) begin
          state_d     = StFeAcc;
          lat_d       = '0;
          acc_addr_d  = i_fe_addr;
          acc_we_d    = 1'b0;
          acc_wdata_d = '0;
          starve_d    = '0;
        end
      end
      StFeAcc, StLdAcc: begin
        if (acc_last) begin
          state_d = StIdle;
          lat_d   = '0;
          if (state_q == StFeAcc) begin
            hold_addr_d  = acc_addr_q;
            hold_data_d  = i_mem_rdata;
            hold_valid_d = 1'b1;
          end else begin
            ld_ack_d = 1'b1;
            if (!acc_we_q) begin
              ld_rdata_d = i_mem_rdata;
            end else if (acc_addr_q == hold_addr_q) begin
              // Loader overwrote the held instruction: force a refetch.
              hold_valid_d = 1'b0;
            end
          end
        end else begin
          lat_d = lat_q + LatW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q      <= StIdle;
      lat_q        <= '0;
      acc_addr_q   <= '0;
      acc_we_q     <= 1'b0;
      acc_wdata_q  <= '0;
      hold_valid_q <= 1'b0;
      hold_addr_q  <= '0;
      hold_data_q  <= '0;
      ld_ack_q     <= 1'b0;
      ld_rdata_q   <= '0;
      starve_q     <= '0;
    end else begin
      state_q      <= state_d;
      lat_q        <= lat_d;
      acc_addr_q   <= acc_addr_d;
      acc_we_q     <= acc_we_d;
      acc_wdata_q  <= acc_wdata_d;
      hold_valid_q <= hold_valid_d;
      hold_addr_q  <= hold_addr_d;
      hold_data_q  <= hold_data_d;
      ld_ack_q     <= ld_ack_d;
      ld_rdata_q   <= ld_rdata_d;
      starve_q     <= starve_d;
    end
  end

endmodule

// File: tb/tb_imem_arb.sv
// Bench for imem_arb: instance 0 has MEM_LAT=1, instance 1 has MEM_LAT=2, both STARVE_MAX=2.
// Behavioural RAM per instance; expected data comes from a shadow copy of memory.
`timescale 1ns / 1ps

module tb_imem_arb;

  localparam int AW = 30;
  localparam int DW = 32;

  typedef struct {
    int            k;
    logic [AW-1:0] addr;
    int            stall;
    int            acc;
  } fe_vec_t;

  typedef struct {
    int            k;
    logic [AW-1:0] a;
  } grant_t;

  logic          clk = 1'b0;
  logic          rst_n     [2];
  logic          fe_req    [2];
  logic [AW-1:0] fe_addr   [2];
  logic [DW-1:0] fe_instr  [2];
  logic          fe_stall  [2];
  logic          ld_req    [2];
  logic          ld_we     [2];
  logic [AW-1:0] ld_addr   [2];
  logic [DW-1:0] ld_wdata  [2];
  logic          ld_ack    [2];
  logic [DW-1:0] ld_rdata  [2];
  logic          mem_en    [2];
  logic          mem_we    [2];
  logic [AW-1:0] mem_addr  [2];
  logic [DW-1:0] mem_wdata [2];
  logic [DW-1:0] mem_rdata [2];

  logic [DW-1:0] ram     [2][64];
  logic [DW-1:0] mod_mem [2][64];
  bit            ram_ready = 1'b0;

  int     acc_cnt [2];
  int     ack_cnt [2];
  bit     en_prev [2];
  grant_t glog [$];

  logic [DW-1:0] exp_fe [$];
  logic [DW-1:0] exp_ld [$];
  fe_vec_t       vecs [8];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    imem_arb #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .MEM_LAT    (g + 1),
      .STARVE_MAX (2)
    ) u_dut (
      .i_clk       (clk),
      .i_arst_n    (rst_n[g]),
      .i_fe_req    (fe_req[g]),
      .i_fe_addr   (fe_addr[g]),
      .o_fe_instr  (fe_instr[g]),
      .o_fe_stall  (fe_stall[g]),
      .i_ld_req    (ld_req[g]),
      .i_ld_we     (ld_we[g]),
      .i_ld_addr   (ld_addr[g]),
      .i_ld_wdata  (ld_wdata[g]),
      .o_ld_ack    (ld_ack[g]),
      .o_ld_rdata  (ld_rdata[g]),
      .o_mem_en    (mem_en[g]),
      .o_mem_we    (mem_we[g]),
      .o_mem_addr  (mem_addr[g]),
      .o_mem_wdata (mem_wdata[g]),
      .i_mem_rdata (mem_rdata[g])
    );
  end

  function automatic logic [DW-1:0] init_word(input int i);
    return 32'h2000_0001 + 32'(i) * 32'h100;
  endfunction

  // RAM: contents loaded on the first edge, then one read/write per enabled cycle.
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int k = 0; k < 2; k++)
        for (int i = 0; i < 64; i++) ram[k][i] <= init_word(i);
      ram_ready <= 1'b1;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (mem_en[k]) begin
          if (mem_we[k]) ram[k][mem_addr[k][5:0]] <= mem_wdata[k];
          else           mem_rdata[k] <= ram[k][mem_addr[k][5:0]];
        end
      end
    end
  end

  // Access/ack monitor: one log entry per rising edge of mem_en.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (mem_en[k] === 1'b1 && !en_prev[k]) begin
        acc_cnt[k] <= acc_cnt[k] + 1;
        glog.push_back('{k: k, a: mem_addr[k]});
      end
      if (ld_ack[k] === 1'b1) ack_cnt[k] <= ack_cnt[k] + 1;
      en_prev[k] <= (mem_en[k] === 1'b1);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts stalled cycles from now until the hit, then checks data and access count.
  task automatic measure(input int k, input int exp_stall, input int exp_acc, input string tag);
    int            cnt;
    int            a0;
    bit            done;
    logic [DW-1:0] instr;
    logic [DW-1:0] exp;
    cnt  = 0;
    done = 1'b0;
    a0   = acc_cnt[k];
    instr = '0;
    while (!done && cnt < 60) begin
      @(negedge clk);
      if (fe_stall[k] === 1'b0) begin
        done  = 1'b1;
        instr = fe_instr[k];
      end else begin
        cnt++;
        tick();
      end
    end
    if (done) tick();
    check({tag, " stall cycles"}, 64'(cnt), 64'(exp_stall));
    if (exp_fe.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s instr: got %0h, expected nothing queued", tag, instr);
    end else begin
      exp = exp_fe.pop_front();
      check({tag, " instr"}, 64'(instr), 64'(exp));
    end
    check({tag, " accesses"}, 64'(acc_cnt[k] - a0), 64'(exp_acc));
  endtask

  task automatic fetch_to(input int k, input logic [AW-1:0] addr, input int exp_stall,
                          input int exp_acc, input string tag);
    fe_req[k]  = 1'b1;
    fe_addr[k] = addr;
    exp_fe.push_back(mod_mem[k][addr[5:0]]);
    measure(k, exp_stall, exp_acc, tag);
  endtask

  // Single loader access; request dropped in the ack cycle.
  task automatic ld_op(input int k, input logic we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wdata, input int exp_cyc, input string tag);
    int            cnt;
    bit            done;
    logic [DW-1:0] exp;
    ld_we[k]    = we;
    ld_addr[k]  = addr;
    ld_wdata[k] = wdata;
    ld_req[k]   = 1'b1;
    if (we) mod_mem[k][addr[5:0]] = wdata;
    else    exp_ld.push_back(mod_mem[k][addr[5:0]]);
    cnt  = 0;
    done = 1'b0;
    while (!done && cnt < 60) begin
      @(negedge clk);
      if (ld_ack[k] === 1'b1) done = 1'b1;
      else begin
        cnt++;
        tick();
      end
    end
    ld_req[k] = 1'b0;
    check({tag, " ack latency"}, 64'(cnt), 64'(exp_cyc));
    if (!we) begin
      exp = exp_ld.pop_front();
      check({tag, " rdata"}, 64'(ld_rdata[k]), 64'(exp));
    end
    if (done) tick();
  endtask

  initial begin
    int            gstart;
    int            cnt;
    int            a0;
    int            ack0;
    bit            done;
    logic [DW-1:0] exp;
    logic [AW-1:0] starve_exp [7];
    logic [AW-1:0] jump_exp [2];
    logic [AW-1:0] seen [$];

    vecs = '{
      '{0, 30'd0, 3, 1},  // first fetch after reset
      '{0, 30'd0, 0, 0},  // hit
      '{0, 30'd5, 3, 1},
      '{1, 30'd0, 4, 1},
      '{1, 30'd1, 4, 1},
      '{1, 30'd2, 4, 1},
      '{1, 30'd2, 0, 0},  // revisit after hit: no access
      '{1, 30'd7, 4, 1}
    };
    starve_exp = '{30'd10, 30'd11, 30'd30, 30'd12, 30'd13, 30'd14, 30'd15};
    jump_exp   = '{30'd4, 30'd20};

    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 64; i++) mod_mem[k][i] = init_word(i);
      rst_n[k]    = 1'b0;
      fe_req[k]   = 1'b0;
      fe_addr[k]  = '0;
      ld_req[k]   = 1'b0;
      ld_we[k]    = 1'b0;
      ld_addr[k]  = '0;
      ld_wdata[k] = '0;
    end
    fe_req[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    check("reset stall0 follows req", 64'(fe_stall[0]), 64'd1);
    check("reset stall1 follows req", 64'(fe_stall[1]), 64'd0);
    check("reset instr", 64'(fe_instr[0]), 64'd0);
    check("reset mem_en", 64'(mem_en[0]), 64'd0);
    check("reset ld_ack", 64'(ld_ack[0]), 64'd0);
    check("reset mem_addr", 64'(mem_addr[0]), 64'd0);

    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;

    for (int i = 0; i < 8; i++)
      fetch_to(vecs[i].k, vecs[i].addr, vecs[i].stall, vecs[i].acc, $sformatf("vec%0d", i));

    // Loader overwrites the held instruction.
    fetch_to(0, 30'd1, 3, 1, "coh fetch");
    fetch_to(0, 30'd1, 0, 0, "coh hit");
    ld_op(0, 1'b1, 30'd1, 32'hDEAD_BEEF, 3, "coh write");
    check("coh stall reasserted", 64'(fe_stall[0]), 64'd1);
    exp_fe.push_back(mod_mem[0][1]);
    measure(0, 2, 1, "coh refetch");

    // Starvation: back-to-back loader reads against a pending fetch.
    gstart     = glog.size();
    fe_addr[0] = 30'd30;
    fe_req[0]  = 1'b1;
    exp_fe.push_back(mod_mem[0][30]);
    for (int a = 10; a < 16; a++) begin
      ld_we[0]   = 1'b0;
      ld_addr[0] = 30'(a);
      ld_req[0]  = 1'b1;
      exp_ld.push_back(mod_mem[0][a]);
      cnt  = 0;
      done = 1'b0;
      while (!done && cnt < 60) begin
        @(negedge clk);
        if (ld_ack[0] === 1'b1) done = 1'b1;
        else begin
          cnt++;
          if (cnt < 60) @(posedge clk);
        end
      end
      exp = exp_ld.pop_front();
      check($sformatf("starve rd%0d rdata", a), 64'(ld_rdata[0]), 64'(exp));
    end
    ld_req[0] = 1'b0;
    tick();
    check("starve fetch done", 64'(fe_stall[0]), 64'd0);
    exp = exp_fe.pop_front();
    check("starve fetch instr", 64'(fe_instr[0]), 64'(exp));
    for (int i = gstart; i < glog.size(); i++)
      if (glog[i].k == 0) seen.push_back(glog[i].a);
    check("starve grant count", 64'(seen.size()), 64'd7);
    for (int i = 0; i < 7; i++) begin
      if (i < seen.size()) check($sformatf("starve grant%0d", i), 64'(seen[i]), 64'(starve_exp[i]));
    end

    // Jump 4 -> 20 while the 4-fetch is in flight (MEM_LAT=2).
    gstart     = glog.size();
    a0         = acc_cnt[1];
    fe_addr[1] = 30'd4;
    exp_fe.push_back(mod_mem[1][20]);
    cnt  = 0;
    done = 1'b0;
    while (!done && cnt < 60) begin
      if (cnt == 2) fe_addr[1] = 30'd20;
      @(negedge clk);
      if (fe_stall[1] === 1'b0) done = 1'b1;
      else begin
        cnt++;
        tick();
      end
    end
    exp = exp_fe.pop_front();
    check("jump instr", 64'(fe_instr[1]), 64'(exp));
    tick();
    check("jump stall cycles", 64'(cnt), 64'd8);
    check("jump accesses", 64'(acc_cnt[1] - a0), 64'd2);
    seen.delete();
    for (int i = gstart; i < glog.size(); i++)
      if (glog[i].k == 1) seen.push_back(glog[i].a);
    check("jump grant count", 64'(seen.size()), 64'd2);
    for (int i = 0; i < 2; i++) begin
      if (i < seen.size()) check($sformatf("jump grant%0d", i), 64'(seen[i]), 64'(jump_exp[i]));
    end

    // Reset during a loader access.
    ld_we[0]   = 1'b0;
    ld_addr[0] = 30'd3;
    ld_req[0]  = 1'b1;
    tick();
    @(negedge clk);
    check("rst in access", 64'(mem_en[0]), 64'd1);
    rst_n[0] = 1'b0;
    #1;
    check("rst mem_en", 64'(mem_en[0]), 64'd0);
    check("rst ld_ack", 64'(ld_ack[0]), 64'd0);
    check("rst mem_addr", 64'(mem_addr[0]), 64'd0);
    check("rst instr", 64'(fe_instr[0]), 64'd0);
    check("rst hold invalid", 64'(fe_stall[0]), 64'd1);
    ld_req[0] = 1'b0;
    fe_req[0] = 1'b0;
    a0   = acc_cnt[0];
    ack0 = ack_cnt[0];
    tick();
    tick();
    rst_n[0] = 1'b1;
    repeat (3) tick();
    check("rst no access", 64'(acc_cnt[0] - a0), 64'd0);
    check("rst no ack", 64'(ack_cnt[0] - ack0), 64'd0);
    ld_op(0, 1'b0, 30'd3, '0, 3, "post-rst read");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/imem_arb.md
# imem_arb

Single-port instruction-memory arbiter between the fetch stage and the program loader (boot/debug write port). Owns the only path to the instruction RAM, sequences multi-cycle accesses, and keeps a one-entry holding register for the fetch address. It raises a stall toward fetch whenever the instruction for the current PC is not yet available. Sits between the fetch stage and the instruction RAM; `o_fe_stall` is ORed into the fetch stage's decode-stall input at the top level.

## Interface
- `ADDR_WIDTH`, 30: word-address width; equals the PC width.
- `DATA_WIDTH`, 32: instruction/data width.
- `MEM_LAT`, 1: RAM read latency in cycles, ≥1.
- `STARVE_MAX`, 4: maximum consecutive loader grants while fetch is waiting, ≥1.

Ports:
- `i_clk` in 1: clock. One clock; all state is on its rising edge.
- `i_arst_n` in 1: reset, asynchronous, active-low.
- `i_fe_req` in 1: fetch needs the instruction at `i_fe_addr`.
- `i_fe_addr` in ADDR_WIDTH: current PC (word address).
- `o_fe_instr` out DATA_WIDTH: held instruction.
- `o_fe_stall` out 1: instruction for `i_fe_addr` not available.
- `i_ld_req` in 1: loader access request; held until `o_ld_ack`.
- `i_ld_we` in 1: 1 = write, 0 = read.
- `i_ld_addr` in ADDR_WIDTH: loader word address.
- `i_ld_wdata` in DATA_WIDTH: loader write data.
- `o_ld_ack` out 1: one-cycle completion pulse.
- `o_ld_rdata` out DATA_WIDTH: loader read data, valid with `o_ld_ack`, held after.
- `o_mem_en` out 1: RAM enable.
- `o_mem_we` out 1: RAM write enable.
- `o_mem_addr` out ADDR_WIDTH: RAM address.
- `o_mem_wdata` out DATA_WIDTH: RAM write data.
- `i_mem_rdata` in DATA_WIDTH: RAM read data.

## Operation
**Reset.** All registered outputs are 0 and the FSM is in IDLE. `hold_valid`=0, `hold_addr`=0, starve counter=0. Consequently `o_fe_stall` = `i_fe_req`.

**Hit and stall.** Hit = `hold_valid` & (`hold_addr` == `i_fe_addr`). `o_fe_stall` = `i_fe_req` & ~hit; this is combinational from registers and `i_fe_addr`. `o_fe_instr` is the hold data, stable between updates.

**Fetch pending.** Fetch is pending when `i_fe_req` & ~hit & no fetch is in flight for `i_fe_addr`.

**FSM states.**
- IDLE: at a clock edge, if the loader requests and (fetch is not pending, or starve counter < STARVE_MAX), go to LD_ACC. Otherwise, if fetch is pending, go to FE_ACC. Otherwise stay in IDLE.
- FE_ACC / LD_ACC: an access occupies MEM_LAT+1 cycles, counted by a latency counter.
  - Cycles 0..MEM_LAT-1: `o_mem_en`=1.
  - All cycles: address, we and wdata are registered at entry and held.
  - Cycle MEM_LAT: `o_mem_en`=0 and `i_mem_rdata` is sampled. The next state is IDLE.
- The access address is latched at entry; later changes to `i_fe_addr` or `i_ld_*` do not affect it.

**Completion.**
- FE_ACC: `hold_addr` ← latched address, hold data ← rdata, `hold_valid` ← 1.
- LD_ACC: `o_ld_ack`=1 for one cycle, the cycle after sampling. For a read, `o_ld_rdata` ← rdata.

**Coherence.** A loader write whose address equals `hold_addr` clears `hold_valid` at completion. If a fetch to the same address was already in flight, that fetch still completes and sets `hold_valid`; the loader write is ordered after it and clears `hold_valid` again.

**Stale fetch.** If the PC changes (jump or exception) while a fetch is in flight:
- the old fetch completes and updates the hold register;
- the hit compare then fails, so a new fetch is issued;
- there is no abort.

**Starvation.** The starve counter increments on each LD_ACC grant while fetch is pending. It clears on an FE_ACC grant or whenever fetch is not pending, and saturates at STARVE_MAX.

**Simultaneous requests in IDLE.** The loader wins unless the starve counter equals STARVE_MAX.

**Reset mid-access.** Return to IDLE immediately. No ack is produced, and the hold register is invalidated.

## Timing
- Fetch miss, arbiter in IDLE, MEM_LAT=1:
  - PC changes in cycle C; grant at the edge ending C.
  - `o_mem_en`=1 in C+1; sample in C+2.
  - `o_fe_stall`=0 from C+3, so the fetch penalty is 3 cycles.
- General miss penalty: MEM_LAT+2 cycles.
- Access throughput: one access per MEM_LAT+2 cycles (access plus IDLE decision cycle).
- Loader: `i_ld_req` rising in cycle L with IDLE and no fetch contention gives `o_ld_ack` in L+MEM_LAT+2.
- Hit: `o_fe_stall`=0 in the same cycle as the address appears; no memory access is issued.

## Test plan
- **Reset, then fetch 0.** `i_fe_req`=1, addr 0, RAM[0]=0x2000_0001, MEM_LAT=1. Expect stall in cycles 0–2 after reset release; cycle 3: stall=0 and `o_fe_instr`=0x2000_0001. Exactly one `o_mem_en` pulse.
- **Sequential PC 0→1→2 with MEM_LAT=2.** Each new address stalls 4 cycles. Returning to addr 2 after a hit on 2 issues no new access.
- **Loader write 0xDEAD_BEEF to addr 1 while `hold_addr`=1.** Ack after MEM_LAT+2 cycles, `hold_valid` cleared, stall reasserts, refetch returns 0xDEAD_BEEF.
- **Starvation, STARVE_MAX=2.** Loader back-to-back reads at addrs 10..15 with fetch pending. Grant order: LD, LD, FE, LD, LD, …; the fetch completes after the 2nd loader ack.
- **Jump mid-fetch.** Addr changes 4→20 during a 4-fetch. The 4-fetch completes, a 20-fetch follows, and stall stays high until the data for 20 is held.
- **Reset mid-access.** Assert `i_arst_n`=0 during LD_ACC. Expect outputs 0 immediately, no `o_ld_ack`, `o_mem_en`=0, and FSM in IDLE after release.
